sp_ram_arbiter: RTL and testbench



---
 rtl/sp_ram_arb_pkg.sv | 34 +++
 rtl/sp_ram_arbiter_rr_arb_2.sv | 51 +++++
 rtl/sp_ram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sp_ram_arb_pkg                                                |
// | Brief    : Shared types and constants for the single-port RAM arbiter.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package sp_ram_arb_pkg;

   // Number of masters sharing the RAM.
   localparam int NUM_MASTERS = 2;

   // Widest address/data a request can carry. Instances narrower than this
   // zero-extend into the request struct and slice back out at the RAM port.
   localparam int MAX_ADDR_WIDTH = 32;
   localparam int MAX_DATA_WIDTH = 64;
   localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

   // Sequencer states: one settle cycle, optional zero-fill, then arbitration.
   typedef enum logic [1:0] {
      RST_WAIT = 2'd0,
      CLEAR    = 2'd1,
      ARB      = 2'd2
   } state_e;

   // One master's RAM access request.
   typedef struct packed {
      logic [MAX_ADDR_WIDTH-1:0] addr;
      logic                      we;
      logic [MAX_BE_WIDTH-1:0]   be;
      logic [MAX_DATA_WIDTH-1:0] wdata;
   } ram_req_t;

endpackage
`default_nettype wire

// File: rtl/sp_ram_arbiter_rr_arb_2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb_2                                                      |
// | Brief    : Two-input round-robin arbiter. One-hot combinational grant,   |
// |            registered last-grant pointer. gnt_accept_i lets the owner    |
// |            suppress grants (e.g. while the slave is busy).               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arb_2 (
   input  logic       clk,
   input  logic       rstn_i,
   input  logic [1:0] req_i,
   input  logic       gnt_accept_i,
   output logic [1:0] gnt_o
);

   // Index of the requester granted most recently; resets to 1 so that
   // requester 0 wins the first tie.
   logic last_gnt_q;
   logic last_gnt_d;

   // Grant: a sole requester wins; on a tie the one not granted last wins.
   always_comb begin
      gnt_o = 2'b00;
      if (gnt_accept_i) begin
         gnt_o[0] = req_i[0] & (~req_i[1] |  last_gnt_q);
         gnt_o[1] = req_i[1] & (~req_i[0] | ~last_gnt_q);
      end
   end

   // Pointer follows whichever requester was actually granted.
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (gnt_o[1]) begin
         last_gnt_d = 1'b1;
      end else if (gnt_o[0]) begin
         last_gnt_d = 1'b0;
      end
   end

   // Last-grant pointer register.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         last_gnt_q <= 1'b1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sp_ram_arbiter                                                |
// | Brief    : Round-robin sharing of one synchronous single-port RAM        |
// |            (1-cycle read latency) between two masters, with an optional  |
// |            zero-fill of the whole RAM after reset.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int RAM_SIZE   = 32768,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int DATA_WIDTH = 32,
   parameter int CLEAR_EN   = 1
) (
   input  logic                    clk,
   input  logic                    rstn_i,

   input  logic                    m0_req_i,
   output logic                    m0_gnt_o,
   output logic                    m0_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,

   input  logic                    m1_req_i,
   output logic                    m1_gnt_o,
   output logic                    m1_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,

   output logic                    ram_en_o,
   output logic                    ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

   output logic                    init_done_o
);

   // DATA_WIDTH must not exceed MAX_DATA_WIDTH, ADDR_WIDTH not MAX_ADDR_WIDTH.
   localparam int BE_WIDTH   = DATA_WIDTH / 8;
   localparam int NUM_WORDS  = RAM_SIZE / BE_WIDTH;
   localparam int CNT_WIDTH  = $clog2(NUM_WORDS);
   localparam int BYTE_SHIFT = $clog2(BE_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_WORDS - 1);

   state_e                 state_q;
   state_e                 state_d;
   logic [CNT_WIDTH-1:0]   clr_cnt_q;
   logic [CNT_WIDTH-1:0]   clr_cnt_d;
   logic                   clr_last;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] gnt;
   logic                   arb_accept;

   ram_req_t               mreq [NUM_MASTERS];
   ram_req_t               sel_req;

   logic                   owner_vld_q;
   logic                   owner_idx_q;

   logic                   unused_sel_bits;

   assign clr_last = (clr_cnt_q == CNT_LAST);

   // State register.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= RST_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: one settle cycle, then the clear (if enabled) until the last
   // word has been written, then arbitration for good.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RST_WAIT: state_d = (CLEAR_EN != 0) ? CLEAR : ARB;
         CLEAR:    state_d = clr_last ? ARB : CLEAR;
         ARB:      state_d = ARB;
         default:  state_d = RST_WAIT;
      endcase
   end

   // Clear word counter advances once per CLEAR cycle and wraps after the last word.
   always_comb begin
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_last ? '0 : clr_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Clear word counter register; a reset restarts the clear from word 0.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         clr_cnt_q <= '0;
      end else begin
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Pack each master's port bundle into the common request struct.
   always_comb begin
      mreq[0]       = '0;
      mreq[0].addr  = MAX_ADDR_WIDTH'(m0_addr_i);
      mreq[0].we    = m0_we_i;
      mreq[0].be    = MAX_BE_WIDTH'(m0_be_i);
      mreq[0].wdata = MAX_DATA_WIDTH'(m0_wdata_i);
      mreq[1]       = '0;
      mreq[1].addr  = MAX_ADDR_WIDTH'(m1_addr_i);
      mreq[1].we    = m1_we_i;
      mreq[1].be    = MAX_BE_WIDTH'(m1_be_i);
      mreq[1].wdata = MAX_DATA_WIDTH'(m1_wdata_i);
   end

   assign req = {m1_req_i, m0_req_i};

   rr_arb_2 u_rr_arb (
      .clk          (clk),
      .rstn_i       (rstn_i),
      .req_i        (req),
      .gnt_accept_i (arb_accept),
      .gnt_o        (gnt)
   );

   // m0 is the default path so that an idle RAM port still has defined values.
   assign sel_req = gnt[1] ? mreq[1] : mreq[0];

   // Zero-extension bits above the instance widths are never needed.
   assign unused_sel_bits = ^{sel_req.addr, sel_req.be, sel_req.wdata};

   // RAM port and arbitration enable, decoded from the current state.
   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      ram_be_o    = '0;
      arb_accept  = 1'b0;
      case (state_q)
         CLEAR: begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_be_o    = '1;
            ram_wdata_o = '0;
            ram_addr_o  = ADDR_WIDTH'(clr_cnt_q) << BYTE_SHIFT;
         end
         ARB: begin
            arb_accept  = 1'b1;
            ram_en_o    = |gnt;
            ram_we_o    = sel_req.we;
            ram_addr_o  = sel_req.addr[ADDR_WIDTH-1:0];
            ram_wdata_o = sel_req.wdata[DATA_WIDTH-1:0];
            ram_be_o    = sel_req.be[BE_WIDTH-1:0];
         end
         default: begin
         end
      endcase
   end

   assign m0_gnt_o    = gnt[0];
   assign m1_gnt_o    = gnt[1];
   assign init_done_o = (state_q == ARB);

   // Remember who owns the RAM response arriving next cycle.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         owner_vld_q <= 1'b0;
         owner_idx_q <= 1'b0;
      end else begin
         owner_vld_q <= |gnt;
         owner_idx_q <= gnt[1];
      end
   end

   // Read data is broadcast; only the owner sees rvalid.
   assign m0_rvalid_o = owner_vld_q & ~owner_idx_q;
   assign m1_rvalid_o = owner_vld_q &  owner_idx_q;
   assign m0_rdata_o  = ram_rdata_i;
   assign m1_rdata_o  = ram_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sp_ram_arbiter                                             |
// | Brief    : Directed self-checking bench for sp_ram_arbiter, one instance |
// |            with the boot clear enabled and one with it disabled, each    |
// |            behind a small behavioural single-port RAM.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sp_ram_arbiter;

   localparam int RS = 64;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int BW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clear-enabled instance ----------------
   logic          rstn;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [BW-1:0] m0_be, m1_be;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m0_rv, m1_gnt, m1_rv;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          ram_en, ram_we, init_done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [BW-1:0] ram_be;
   logic [DW-1:0] ram_rdata;
   logic          fill;
   logic [DW-1:0] mem [RS/BW];

   sp_ram_arbiter #(.RAM_SIZE(RS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_EN(1)) dut (
      .clk(clk), .rstn_i(rstn),
      .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_addr_i(m0_addr),
      .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_addr_i(m1_addr),
      .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .ram_be_o(ram_be), .ram_rdata_i(ram_rdata), .init_done_o(init_done)
   );

   // Behavioural synchronous RAM, 1-cycle read latency, byte-enabled writes.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < RS/BW; i++) mem[i] <= 32'hA5A5A5A5;
      end else if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < BW; b++)
               if (ram_be[b]) mem[ram_addr[AW-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else begin
            ram_rdata <= mem[ram_addr[AW-1:2]];
         end
      end
   end

   // ---------------- clear-disabled instance ----------------
   logic          nc_rstn;
   logic          nc_m0_req, nc_m0_we, nc_m1_req, nc_m1_we;
   logic [AW-1:0] nc_m0_addr, nc_m1_addr;
   logic [BW-1:0] nc_m0_be, nc_m1_be;
   logic [DW-1:0] nc_m0_wdata, nc_m1_wdata;
   logic          nc_m0_gnt, nc_m0_rv, nc_m1_gnt, nc_m1_rv;
   logic [DW-1:0] nc_m0_rdata, nc_m1_rdata;
   logic          nc_ram_en, nc_ram_we, nc_init_done;
   logic [AW-1:0] nc_ram_addr;
   logic [DW-1:0] nc_ram_wdata;
   logic [BW-1:0] nc_ram_be;
   logic [DW-1:0] nc_ram_rdata;
   logic [DW-1:0] nc_mem [RS/BW];

   sp_ram_arbiter #(.RAM_SIZE(RS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_EN(0)) dut_nc (
      .clk(clk), .rstn_i(nc_rstn),
      .m0_req_i(nc_m0_req), .m0_gnt_o(nc_m0_gnt), .m0_rvalid_o(nc_m0_rv), .m0_addr_i(nc_m0_addr),
      .m0_we_i(nc_m0_we), .m0_be_i(nc_m0_be), .m0_wdata_i(nc_m0_wdata), .m0_rdata_o(nc_m0_rdata),
      .m1_req_i(nc_m1_req), .m1_gnt_o(nc_m1_gnt), .m1_rvalid_o(nc_m1_rv), .m1_addr_i(nc_m1_addr),
      .m1_we_i(nc_m1_we), .m1_be_i(nc_m1_be), .m1_wdata_i(nc_m1_wdata), .m1_rdata_o(nc_m1_rdata),
      .ram_en_o(nc_ram_en), .ram_we_o(nc_ram_we), .ram_addr_o(nc_ram_addr), .ram_wdata_o(nc_ram_wdata),
      .ram_be_o(nc_ram_be), .ram_rdata_i(nc_ram_rdata), .init_done_o(nc_init_done)
   );

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < RS/BW; i++) nc_mem[i] <= 32'hC0DE0000 | i;
      end else if (nc_ram_en) begin
         if (nc_ram_we) begin
            for (int b = 0; b < BW; b++)
               if (nc_ram_be[b]) nc_mem[nc_ram_addr[AW-1:2]][8*b +: 8] <= nc_ram_wdata[8*b +: 8];
         end else begin
            nc_ram_rdata <= nc_mem[nc_ram_addr[AW-1:2]];
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] wdata);
      m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wdata;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] wdata);
      m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wdata;
   endtask

   // Release reset on a negedge and follow the whole boot clear of the
   // clear-enabled instance; returns in the first ARB cycle (after #1).
   task automatic release_and_clear(input string tag);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_eq({tag, "_rst_wait"}, {59'd0, ram_en, ram_we, m0_gnt, m1_gnt, init_done}, 64'd0);
      for (int k = 0; k < RS/BW; k++) begin
         @(negedge clk); #1;
         check_eq($sformatf("%s_clear%0d", tag, k),
                  {17'd0, ram_en, ram_we, m0_gnt, m1_gnt, init_done, ram_be, ram_addr, ram_wdata},
                  {17'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 6'(k*4), 32'h0});
      end
      @(negedge clk); #1;
      check_eq({tag, "_init_done"}, {63'd0, init_done}, 64'd1);
   endtask

   // Watchdog: every wait is clock-bounded, this only guards against surprises.
   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rstn = 1'b0; nc_rstn = 1'b0; fill = 1'b1;
      set_m0(1'b0, 1'b0, '0, '0, '0);
      set_m1(1'b0, 1'b0, '0, '0, '0);
      nc_m0_req = 1'b0; nc_m0_we = 1'b0; nc_m0_addr = '0; nc_m0_be = '0; nc_m0_wdata = '0;
      nc_m1_req = 1'b0; nc_m1_we = 1'b0; nc_m1_addr = '0; nc_m1_be = '0; nc_m1_wdata = '0;
      repeat (3) @(negedge clk);
      fill = 1'b0;
      #1;
      check_eq("reset_outputs", {57'd0, m0_gnt, m1_gnt, m0_rv, m1_rv, init_done, ram_en, ram_we}, 64'd0);

      // m0 holds a write request through the whole clear; it must wait.
      set_m0(1'b1, 1'b1, 6'h10, 4'hF, 32'hDEADBEEF);
      release_and_clear("boot");
      check_eq("wr_gnt", {18'd0, m0_gnt, m1_gnt, ram_en, ram_we, ram_addr, ram_wdata},
               {18'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'h10, 32'hDEADBEEF});

      @(negedge clk); set_m0(1'b1, 1'b0, 6'h10, 4'hF, 32'h0); #1;
      check_eq("rd_gnt_wr_rv", {61'd0, m0_gnt, m0_rv, m1_rv}, 64'b110);
      @(negedge clk); set_m0(1'b0, 1'b0, 6'h10, 4'hF, 32'h0); #1;
      check_eq("rd_rv", {61'd0, m0_gnt, m0_rv, m1_rv}, 64'b010);
      check_eq("rd_data", {32'd0, m0_rdata}, {32'd0, 32'hDEADBEEF});

      // m1 preloads word 0x20, making m1 the last grantee.
      @(negedge clk); set_m1(1'b1, 1'b1, 6'h20, 4'hF, 32'h11223344); #1;
      check_eq("m1_wr_gnt", {60'd0, m0_gnt, m1_gnt, m0_rv, m1_rv}, 64'b0100);

      // Both request for 6 cycles: m0, m1, m0, m1, m0, m1.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         set_m0(1'b1, 1'b0, 6'h10, 4'hF, 32'h0);
         set_m1(1'b1, 1'b0, 6'h20, 4'hF, 32'h0);
         #1;
         // The previous cycle's grant was m1 for i even, m0 for i odd.
         check_eq($sformatf("rr%0d", i), {60'd0, m0_gnt, m1_gnt, m0_rv, m1_rv},
                  (i % 2 == 0) ? 64'b1001 : 64'b0110);
         if (i > 0)
            check_eq($sformatf("rr%0d_data", i), {32'd0, (i % 2 == 0) ? m1_rdata : m0_rdata},
                     {32'd0, (i % 2 == 0) ? 32'h11223344 : 32'hDEADBEEF});
      end
      @(negedge clk);
      set_m0(1'b0, 1'b0, '0, '0, '0);
      set_m1(1'b0, 1'b0, '0, '0, '0);
      #1;
      check_eq("rr_tail", {60'd0, m0_gnt, m1_gnt, m0_rv, m1_rv}, 64'b0001);
      check_eq("rr_tail_data", {32'd0, m1_rdata}, {32'd0, 32'h11223344});

      // Byte-lane write: only byte 2 of 0x11223344 changes.
      @(negedge clk); set_m1(1'b1, 1'b1, 6'h20, 4'b0100, 32'h00AA0000); #1;
      check_eq("be_wr_gnt", {63'd0, m1_gnt}, 64'd1);
      @(negedge clk); set_m1(1'b1, 1'b0, 6'h20, 4'hF, 32'h0); #1;
      check_eq("be_rd_gnt", {62'd0, m1_gnt, m1_rv}, 64'b11);
      @(negedge clk); set_m1(1'b0, 1'b0, '0, '0, '0); #1;
      check_eq("be_rd_rv", {63'd0, m1_rv}, 64'd1);
      check_eq("be_rd_data", {32'd0, m1_rdata}, {32'd0, 32'h11AA3344});

      // Reset pulse while a read is being granted: no rvalid, clear restarts.
      @(negedge clk); set_m0(1'b1, 1'b0, 6'h10, 4'hF, 32'h0); #1;
      check_eq("mid_rst_gnt", {63'd0, m0_gnt}, 64'd1);
      #1; rstn = 1'b0; set_m0(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk); #1;
      check_eq("mid_rst_no_rv", {60'd0, m0_rv, m1_rv, init_done, ram_en}, 64'd0);
      release_and_clear("reclear");
      @(negedge clk); set_m0(1'b1, 1'b0, 6'h10, 4'hF, 32'h0); #1;
      check_eq("post_clr_gnt", {63'd0, m0_gnt}, 64'd1);
      @(negedge clk); set_m0(1'b0, 1'b0, '0, '0, '0); #1;
      check_eq("post_clr_rv", {63'd0, m0_rv}, 64'd1);
      check_eq("post_clr_data", {32'd0, m0_rdata}, 64'd0);

      // Clear disabled: grant one cycle after release, RAM untouched.
      nc_m0_req = 1'b1; nc_m0_we = 1'b0; nc_m0_addr = 6'h10; nc_m0_be = 4'hF;
      @(negedge clk); nc_rstn = 1'b1; #1;
      check_eq("nc_rst_wait", {61'd0, nc_m0_gnt, nc_init_done, nc_ram_en}, 64'd0);
      @(negedge clk); #1;
      check_eq("nc_first_gnt", {54'd0, nc_m0_gnt, nc_init_done, nc_ram_en, nc_ram_we, nc_ram_addr},
               {54'd0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h10});
      @(negedge clk); nc_m0_req = 1'b0; #1;
      check_eq("nc_rv", {63'd0, nc_m0_rv}, 64'd1);
      check_eq("nc_data", {32'd0, nc_m0_rdata}, {32'd0, 32'hC0DE0004});
      check_eq("nc_mem0", {32'd0, nc_mem[0]}, {32'd0, 32'hC0DE0000});
      check_eq("nc_mem15", {32'd0, nc_mem[15]}, {32'd0, 32'hC0DE000F});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
